// File: rtl/lut_logic_pkg.sv
// lut_logic_pkg: shared types and helpers for the LUT logic unit.
//   - state_e      : sweep FSM states (IDLE, SWEEP, DONE)
//   - SIG_MAX      : widest signature the fold helper supports
//   - tbl_width    : truth-table width for a given input count (2**n_in)
//   - func_idx_w   : width of the function-select index (at least 1)
//   - sig_fold     : one signature step, rotate-left-by-one then XOR
package lut_logic_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int unsigned SIG_MAX = 64;

    function automatic int unsigned tbl_width(input int unsigned n_in);
        return 32'd1 << n_in;
    endfunction

    function automatic int unsigned func_idx_w(input int unsigned n_func);
        return (n_func > 32'd1) ? $clog2(n_func) : 32'd1;
    endfunction

    // Rotate sig left by one within w bits, then XOR in r. Bits at or above
    // w are cleared; for w == SIG_MAX the shifted-out mask wraps to all ones.
    function automatic logic [SIG_MAX-1:0] sig_fold(
        input logic [SIG_MAX-1:0] sig,
        input logic [SIG_MAX-1:0] r,
        input int unsigned        w
    );
        logic [SIG_MAX-1:0] mask;
        mask = (64'd1 << w) - 64'd1;
        return (((sig << 1) | (sig >> (w - 32'd1))) ^ r) & mask;
    endfunction

endpackage

// File: rtl/lut_logic_table.sv
// lut_logic_table: register array of N_FUNC truth tables of 2**N_IN bits.
// Ports:
//   clk, rst_n      clock, async active-low reset (tables clear to 0)
//   we_i            write strobe (already qualified by the caller's state)
//   func_i          table to write; indices >= N_FUNC are ignored
//   data_i          new truth table contents
//   eval_idx_i      read index for evaluation port
//   sweep_idx_i     read index for sweep port
//   eval_o/sweep_o  bit j = table[j][index], combinational
module lut_logic_table
    import lut_logic_pkg::*;
#(
    parameter int unsigned N_IN   = 3,
    parameter int unsigned N_FUNC = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          we_i,
    input  logic [func_idx_w(N_FUNC)-1:0] func_i,
    input  logic [tbl_width(N_IN)-1:0]    data_i,
    input  logic [N_IN-1:0]               eval_idx_i,
    input  logic [N_IN-1:0]               sweep_idx_i,
    output logic [N_FUNC-1:0]             eval_o,
    output logic [N_FUNC-1:0]             sweep_o
);

    localparam int unsigned TW = tbl_width(N_IN);

    logic [TW-1:0] tbl_q [N_FUNC];

    // Table storage; comparing against every legal index drops out-of-range writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < int'(N_FUNC); j++) begin
                tbl_q[j] <= '0;
            end
        end else begin
            for (int j = 0; j < int'(N_FUNC); j++) begin
                if (we_i && (int'(func_i) == j)) begin
                    tbl_q[j] <= data_i;
                end
            end
        end
    end

    // Two independent combinational read ports.
    always_comb begin
        eval_o  = '0;
        sweep_o = '0;
        for (int j = 0; j < int'(N_FUNC); j++) begin
            eval_o[j]  = tbl_q[j][eval_idx_i];
            sweep_o[j] = tbl_q[j][sweep_idx_i];
        end
    end

endmodule

// File: rtl/lut_logic_unit.sv
// lut_logic_unit: N_FUNC programmable Boolean functions of N_IN inputs with a
// valid/ready registered output and an exhaustive self-test sweep engine.
// Optional build macro: LUT_OUT_PARITY_EN adds out_par (= ^out_vec, held with
// out_vec) and folds the parity of each sweep row into sweep_sig[SIG_W-1].
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   cfg_we, cfg_func, cfg_table   truth-table write (honoured only in IDLE)
//   in_valid, in_ready, in_vec    evaluation request handshake
//   out_valid, out_ready, out_vec result handshake (1-cycle latency)
//   sweep_start                   level-sampled sweep request in IDLE
//   sweep_busy, sweep_done        sweep in progress / completion pulse
//   sweep_sig                     signature of the last completed sweep
module lut_logic_unit
    import lut_logic_pkg::*;
#(
    parameter int unsigned N_IN   = 3,
    parameter int unsigned N_FUNC = 3,
    parameter int unsigned SIG_W  = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cfg_we,
    input  logic [func_idx_w(N_FUNC)-1:0] cfg_func,
    input  logic [tbl_width(N_IN)-1:0]    cfg_table,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [N_IN-1:0]               in_vec,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [N_FUNC-1:0]             out_vec,
`ifdef LUT_OUT_PARITY_EN
    output logic                          out_par,
`endif
    input  logic                          sweep_start,
    output logic                          sweep_busy,
    output logic                          sweep_done,
    output logic [SIG_W-1:0]              sweep_sig
);

    state_e              state_q;
    logic [N_IN-1:0]     idx_q;
    logic [SIG_W-1:0]    sig_q;
    logic [SIG_W-1:0]    sig_d;
    logic                busy_q;
    logic                done_q;
    logic                out_valid_q;
    logic [N_FUNC-1:0]   out_vec_q;
    logic [N_FUNC-1:0]   eval_r_s;
    logic [N_FUNC-1:0]   sweep_r_s;
    logic                accept_s;
    logic                tbl_we_s;
    logic [SIG_MAX-1:0]  r_ext_s;
    logic [SIG_MAX-1:0]  sig_ext_s;
    logic [SIG_MAX-1:0]  fold_s;

    assign in_ready   = (state_q == IDLE) && (!out_valid_q || out_ready);
    assign accept_s   = in_valid && in_ready;
    assign tbl_we_s   = cfg_we && (state_q == IDLE);
    assign out_valid  = out_valid_q;
    assign out_vec    = out_vec_q;
    assign sweep_busy = busy_q;
    assign sweep_done = done_q;
    assign sweep_sig  = sig_q;

    lut_logic_table #(
        .N_IN   (N_IN),
        .N_FUNC (N_FUNC)
    ) u_table (
        .clk         (clk),
        .rst_n       (rst_n),
        .we_i        (tbl_we_s),
        .func_i      (cfg_func),
        .data_i      (cfg_table),
        .eval_idx_i  (in_vec),
        .sweep_idx_i (idx_q),
        .eval_o      (eval_r_s),
        .sweep_o     (sweep_r_s)
    );

    // Next signature value for the row currently addressed by idx_q.
    always_comb begin
        r_ext_s                  = '0;
        r_ext_s[N_FUNC-1:0]      = sweep_r_s;
        sig_ext_s                = '0;
        sig_ext_s[SIG_W-1:0]     = sig_q;
        fold_s                   = sig_fold(sig_ext_s, r_ext_s, SIG_W);
        sig_d                    = fold_s[SIG_W-1:0];
`ifdef LUT_OUT_PARITY_EN
        sig_d[SIG_W-1]           = fold_s[SIG_W-1] ^ (^sweep_r_s);
`endif
    end

    // Sweep FSM with registered busy/done/signature outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            sig_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (sweep_start) begin
                        state_q <= SWEEP;
                        idx_q   <= '0;
                        sig_q   <= '0;
                        busy_q  <= 1'b1;
                    end else begin
                        busy_q  <= 1'b0;
                    end
                end
                SWEEP: begin
                    sig_q <= sig_d;
                    idx_q <= idx_q + N_IN'(1);
                    // Last row processed this cycle: drop busy and pulse done.
                    if (idx_q == '1) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        busy_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    // Output register: load on accept, clear on handshake, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_vec_q   <= '0;
        end else if (accept_s) begin
            out_valid_q <= 1'b1;
            out_vec_q   <= eval_r_s;
        end else if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

`ifdef LUT_OUT_PARITY_EN
    logic out_par_q;

    // Parity bit registered alongside out_vec under the same load rule.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_par_q <= 1'b0;
        end else if (accept_s) begin
            out_par_q <= ^eval_r_s;
        end
    end

    assign out_par = out_par_q;
`endif

endmodule

// File: doc/lut_logic_unit.md
Name: lut_logic_unit

Overview:
- Parametrised, registered successor to the team's fixed 3-input logic-function blocks.
- Evaluates N_FUNC independently programmable Boolean functions of N_IN inputs, each stored as a 2**N_IN-bit truth table.
- Results go out through a valid/ready output register.
- A built-in sweep engine walks every input combination and folds the results into a signature, giving on-chip exhaustive self-test of the programmed functions.

Parameters:
- N_IN, 3, number of function inputs (1..6)
- N_FUNC, 3, number of functions/output bits (1..8)
- SIG_W, 16, sweep signature width (must be >= N_FUNC)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- cfg_we  input  1  truth-table write strobe
- cfg_func  input  max(1,$clog2(N_FUNC))  function index to write
- cfg_table  input  2**N_IN  truth table; bit k = f(in_vec==k)
- in_valid  input  1  evaluation request
- in_ready  output  1  request accepted when in_valid && in_ready
- in_vec  input  N_IN  input vector, used as unsigned table index
- out_valid  output  1  out_vec holds a result
- out_ready  input  1  consumer accepts result
- out_vec  output  N_FUNC  bit j = table[j][in_vec]
- sweep_start  input  1  start exhaustive sweep (level-sampled in IDLE)
- sweep_busy  output  1  sweep in progress
- sweep_done  output  1  one-cycle pulse at sweep completion
- sweep_sig  output  SIG_W  signature of last sweep

Behaviour:
- Reset (async assert, sync release): all tables = 0; out_valid=0; out_vec=0; sweep_busy=0; sweep_done=0; sweep_sig=0; FSM=IDLE.
- Config:
  - cfg_we is honoured only in IDLE; ignored in SWEEP/DONE.
  - cfg_func >= N_FUNC is ignored.
  - A write takes effect the following cycle. An evaluation accepted in the same cycle uses the old table.
- Evaluation:
  - in_ready = (state==IDLE) && (!out_valid || out_ready).
  - On accept, out_vec is registered next cycle and out_valid=1. Latency is 1 cycle.
  - Back-to-back throughput is 1/cycle while out_ready=1.
  - out_vec and out_valid hold stable while out_valid && !out_ready.
  - out_valid clears on handshake if there is no new accept.
- FSM states:
  - IDLE -> SWEEP when sweep_start=1. On entry: idx=0, sweep_sig=0, sweep_busy=1.
  - SWEEP, each cycle:
    - r = {table[N_FUNC-1][idx] .. table[0][idx]}
    - sweep_sig <= rotl(sweep_sig,1) ^ zero_ext(r)
    - idx++
    - After idx==2**N_IN-1 is processed: -> DONE.
  - DONE: sweep_busy=0, sweep_done=1 for exactly this cycle, then -> IDLE.
- Timing: start sampled in cycle t; sweep_done high in cycle t+2**N_IN+1; sweep_sig valid from that cycle until the next start or reset.
- Sweep does not touch out_vec/out_valid. A pending output result is held and may be drained during the sweep.
- sweep_start held high re-triggers from IDLE after DONE.
- sweep_start while in SWEEP/DONE is ignored.
- Reset mid-sweep: immediate return to IDLE with all reset values; the partial signature is lost.

Optional Feature:
- Macro LUT_OUT_PARITY_EN.
- Defined:
  - Extra output out_par (1 bit) = ^out_vec, registered alongside out_vec with the same hold rules; reset 0.
  - The sweep XORs the parity of r into sweep_sig bit SIG_W-1 after the fold.
- Undefined: no out_par port; signature exactly as above.

Decomposition:
- Package lut_logic_pkg holds:
  - FSM state enum {IDLE, SWEEP, DONE}
  - signature fold function (rotl-xor)
  - parameter legality localparams: table width 2**N_IN, index width
- One natural sub-module: lut_logic_table.
  - Register array of N_FUNC tables with write port and two combinational read ports (eval index, sweep index).
  - Instantiated once.

Test Plan (defaults N_IN=3, N_FUNC=3, SIG_W=16):
- Reset: assert rst_n=0 mid-cycle -> out_valid=0, out_vec=0, sweep_sig=16'h0000, in_ready=1 after release.
- Program and evaluate:
  - Program f0=8'hE8 (majority), f1=8'h96 (xor3), f2=8'h01.
  - in_vec=3'b011 -> out_vec=3'b001 next cycle.
  - in_vec=3'b000 -> 3'b100.
  - in_vec=3'b111 -> 3'b011.
- Backpressure:
  - out_ready=0 with out_valid=1 -> in_ready=0; out_vec held for 5 cycles.
  - Release -> handshake, and a queued request is accepted the same cycle.
- Write/eval collision: cfg_we (f0 := 8'h00) and accept in_vec=3'b111 in the same cycle -> out_vec[0]=1; next eval of 3'b111 gives out_vec[0]=0.
- Sweep:
  - Tables f0=E8, f1=96, f2=00; pulse sweep_start.
  - sweep_busy for 8 cycles; sweep_done at start+9.
  - sweep_sig=16'h00C5.
  - cfg_we during the sweep is ignored (tables unchanged, re-sweep gives 16'h00C5).
- Reset mid-sweep: assert rst_n at idx=4 -> FSM IDLE, sweep_busy=0, sweep_sig=0, tables all zero.
  - Re-sweep afterwards -> 16'h0000.
